// File: rtl/key_conditioner.sv
// key_conditioner: turns raw board push-buttons into clean pressed-high levels
// for game_top.keys_i, plus one-cycle press/release strobes for menu logic.
// Each key passes through a 2-flop synchroniser, an optional polarity flip
// and an independent debounce counter.
// Optional feature macro: KEY_REPEAT_EN adds auto-repeat press strobes while
// a key is held (first after REPEAT_DELAY cycles, then every REPEAT_PERIOD).
// Key count defaults to the `KEYS_W macro shared with game_top.

`ifndef KEYS_W
`define KEYS_W 4
`endif

module key_conditioner #(
  parameter int KEYS_W          = `KEYS_W,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [KEYS_W-1:0] keys_raw_i,
  output logic [KEYS_W-1:0] keys_o,
  output logic [KEYS_W-1:0] keys_press_o,
  output logic [KEYS_W-1:0] keys_release_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Polarity mask: XOR with it makes the synchronised level pressed-high,
  // and it is also the idle raw level the sync flops reset to.
  localparam logic [KEYS_W-1:0] POL_MASK = (KEY_ACTIVE_LOW != 0) ? {KEYS_W{1'b1}} : {KEYS_W{1'b0}};

  logic [KEYS_W-1:0] sync1_r;
  logic [KEYS_W-1:0] sync2_r;
  logic [KEYS_W-1:0] s_s;
  logic [CNT_W-1:0]  cnt_r     [KEYS_W];
  logic [CNT_W-1:0]  cnt_nxt_s [KEYS_W];
  logic [KEYS_W-1:0] accept_s;
  logic [KEYS_W-1:0] level_r;
  logic [KEYS_W-1:0] level_nxt_s;
  logic [KEYS_W-1:0] rise_s;
  logic [KEYS_W-1:0] fall_s;
  logic [KEYS_W-1:0] press_nxt_s;
  logic [KEYS_W-1:0] press_r;
  logic [KEYS_W-1:0] release_r;

  assign keys_o         = level_r;
  assign keys_press_o   = press_r;
  assign keys_release_o = release_r;

  // Debounce decision: a change is accepted only after DEBOUNCE_CYCLES
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    s_s = sync2_r ^ POL_MASK;
    for (int k = 0; k < KEYS_W; k++) begin
      cnt_nxt_s[k] = {CNT_W{1'b0}};
      accept_s[k]  = 1'b0;
      if (s_s[k] == level_r[k]) begin
        cnt_nxt_s[k] = {CNT_W{1'b0}};
        accept_s[k]  = 1'b0;
      end else if (cnt_r[k] == CNT_LAST) begin
        cnt_nxt_s[k] = {CNT_W{1'b0}};
        accept_s[k]  = 1'b1;
      end else begin
        cnt_nxt_s[k] = cnt_r[k] + CNT_W'(1);
        accept_s[k]  = 1'b0;
      end
    end
    level_nxt_s = level_r ^ accept_s;
    rise_s      = accept_s & level_nxt_s;
    fall_s      = accept_s & ~level_nxt_s;
  end

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0]  rep_cnt_r     [KEYS_W];
  logic [REP_W-1:0]  rep_cnt_nxt_s [KEYS_W];
  logic [KEYS_W-1:0] rep_armed_r;
  logic [KEYS_W-1:0] rep_armed_nxt_s;
  logic [KEYS_W-1:0] rep_hit_s;

  // Repeat timing: counts held cycles since the press edge; the first hit
  // uses the long delay, later hits the shorter period. Not held, or being
  // released this edge, clears everything so no repeat can meet a release.
  always_comb begin
    for (int k = 0; k < KEYS_W; k++) begin
      rep_cnt_nxt_s[k]   = {REP_W{1'b0}};
      rep_armed_nxt_s[k] = 1'b0;
      rep_hit_s[k]       = 1'b0;
      if ((level_r[k] == 1'b0) || (level_nxt_s[k] == 1'b0)) begin
        rep_cnt_nxt_s[k]   = {REP_W{1'b0}};
        rep_armed_nxt_s[k] = 1'b0;
        rep_hit_s[k]       = 1'b0;
      end else if (rep_cnt_r[k] == (rep_armed_r[k] ? REP_PERIOD_LAST : REP_DELAY_LAST)) begin
        rep_cnt_nxt_s[k]   = {REP_W{1'b0}};
        rep_armed_nxt_s[k] = 1'b1;
        rep_hit_s[k]       = 1'b1;
      end else begin
        rep_cnt_nxt_s[k]   = rep_cnt_r[k] + REP_W'(1);
        rep_armed_nxt_s[k] = rep_armed_r[k];
        rep_hit_s[k]       = 1'b0;
      end
    end
    press_nxt_s = rise_s | rep_hit_s;
  end

  // Repeat counter and armed flag per key.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < KEYS_W; k++) rep_cnt_r[k] <= {REP_W{1'b0}};
      rep_armed_r <= {KEYS_W{1'b0}};
    end else begin
      for (int k = 0; k < KEYS_W; k++) rep_cnt_r[k] <= rep_cnt_nxt_s[k];
      rep_armed_r <= rep_armed_nxt_s;
    end
  end
`else
  // Press strobe is the accepted rising edge only.
  always_comb begin
    press_nxt_s = rise_s;
  end
`endif

  // Synchroniser, debounce counters, debounced level and registered strobes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_r   <= POL_MASK;
      sync2_r   <= POL_MASK;
      for (int k = 0; k < KEYS_W; k++) cnt_r[k] <= {CNT_W{1'b0}};
      level_r   <= {KEYS_W{1'b0}};
      press_r   <= {KEYS_W{1'b0}};
      release_r <= {KEYS_W{1'b0}};
    end else begin
      sync1_r   <= keys_raw_i;
      sync2_r   <= sync1_r;
      for (int k = 0; k < KEYS_W; k++) cnt_r[k] <= cnt_nxt_s[k];
      level_r   <= level_nxt_s;
      press_r   <= press_nxt_s;
      release_r <= fall_s;
    end
  end

endmodule
